// File: rtl/cariomart_pkg.sv
// Shared types and default parameters for the cariomart input conditioning path.
package cariomart_pkg;

   // Debounce FSM state encoding
   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_e;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
   localparam int unsigned DEF_SRC_FILTER      = 3;
   localparam int unsigned DEF_PERIOD_W        = 24;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous pins; both stages reset to 0.
module sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // First stage may go metastable; second stage is the usable copy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/input_conditioner.sv
// Cleans the raw button and source pins: synchronize, debounce the button,
// glitch-filter the source, emit rising-edge pulses and measure source period.
module input_conditioner
   import cariomart_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SRC_FILTER      = DEF_SRC_FILTER,
   parameter int unsigned PERIOD_W        = DEF_PERIOD_W
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                button,
   input  logic                source,
   output logic                button_clean,
   output logic                button_press,
   output logic                source_clean,
   output logic                source_edge,
   output logic [PERIOD_W-1:0] source_period,
   output logic                period_valid,
   output logic                period_ovf
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PMAX = '1;

   logic b_s;
   logic s_s;

   sync2 #(.W(1)) u_sync_button (
      .clk_i  (PCLK),
      .rst_ni (PRESERN),
      .d_i    (button),
      .q_o    (b_s)
   );

   sync2 #(.W(1)) u_sync_source (
      .clk_i  (PCLK),
      .rst_ni (PRESERN),
      .d_i    (source),
      .q_o    (s_s)
   );

   // ---------------- button debounce ----------------
   db_state_e     state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          bclean_q, bclean_d;
   logic          bpress_q, bpress_d;

   // Debounce state, counter and registered button outputs
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q  <= LOW;
         dcnt_q   <= '0;
         bclean_q <= 1'b0;
         bpress_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dcnt_q   <= dcnt_d;
         bclean_q <= bclean_d;
         bpress_q <= bpress_d;
      end
   end

   // Any return to the old level during WAIT_* discards all progress
   always_comb begin
      state_d  = state_q;
      dcnt_d   = dcnt_q;
      bclean_d = bclean_q;
      bpress_d = 1'b0;
      unique case (state_q)
         LOW: begin
            if (b_s) begin
               state_d = WAIT_HIGH;
               dcnt_d  = DW'(1);
            end
         end
         WAIT_HIGH: begin
            if (!b_s) begin
               state_d = LOW;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d  = HIGH;
               bclean_d = 1'b1;
               bpress_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         HIGH: begin
            if (!b_s) begin
               state_d = WAIT_LOW;
               dcnt_d  = DW'(1);
            end
         end
         WAIT_LOW: begin
            if (b_s) begin
               state_d = HIGH;
            end else if (dcnt_q == DCNT_LAST) begin
               state_d  = LOW;
               bclean_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = LOW;
      endcase
   end

   // ---------------- source glitch filter ----------------
   // Window is the live synchronized sample plus SRC_FILTER-1 older ones,
   // so a stable change lands on source_clean SRC_FILTER+2 edges later.
   logic [SRC_FILTER-1:0] win;

   if (SRC_FILTER > 1) begin : g_hist
      logic [SRC_FILTER-2:0] hist_q;

      // Shift register of past synchronized source samples
      always_ff @(posedge PCLK or negedge PRESERN) begin
         if (!PRESERN) hist_q <= '0;
         else          hist_q <= win[SRC_FILTER-2:0];
      end

      assign win = {hist_q, s_s};
   end else begin : g_nohist
      assign win = s_s;
   end

   logic all1, all0, src_rise;
   logic sclean_q, sedge_q;

   assign all1     = &win;
   assign all0     = ~|win;
   assign src_rise = all1 & ~sclean_q;

   // Filtered level and its rising-edge pulse
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         sclean_q <= 1'b0;
         sedge_q  <= 1'b0;
      end else begin
         sedge_q <= src_rise;
         if (all1)      sclean_q <= 1'b1;
         else if (all0) sclean_q <= 1'b0;
      end
   end

   // ---------------- period measurement ----------------
   logic [PERIOD_W-1:0] pcnt_q, pinc, per_q;
   logic                pfull, armed_q, valid_q, ovf_q;

   assign pfull = (pcnt_q == PMAX);
   assign pinc  = pfull ? PMAX : pcnt_q + PERIOD_W'(1);

   // Edge reloads the counter; the first edge after reset only arms
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         pcnt_q  <= '0;
         armed_q <= 1'b0;
         per_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (src_rise) begin
         pcnt_q  <= '0;
         armed_q <= 1'b1;
         if (armed_q) begin
            per_q   <= pinc;
            ovf_q   <= pfull;
            valid_q <= 1'b1;
         end
      end else begin
         pcnt_q <= pinc;
      end
   end

   assign button_clean  = bclean_q;
   assign button_press  = bpress_q;
   assign source_clean  = sclean_q;
   assign source_edge   = sedge_q;
   assign source_period = per_q;
   assign period_valid  = valid_q;
   assign period_ovf    = ovf_q;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the raw `button` and `source` pins of the cariomart fabric before they reach `interupt_generator_mux`. Each pin passes through a two-flop synchronizer. `button` then passes through a debounce state machine and `source` through a short glitch filter. The block produces clean levels, single-cycle rising-edge pulses and a measured `source` period. It runs on the MSS fabric clock and reset (`FAB_CLK` / `M2F_RESET_N`) and sits directly upstream of the interrupt generator.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles `button` must hold a new value before it is accepted; minimum 2.
- `SRC_FILTER`, default 3: consecutive equal synchronized samples needed to change `source_clean`; minimum 1.
- `PERIOD_W`, default 24: width of the period counter and result.
- `PCLK` in 1: fabric clock, driven from `FAB_CLK`.
- `PRESERN` in 1: reset, asynchronous, active-low, driven from `M2F_RESET_N`.
- `button` in 1: raw push-button pin, asynchronous.
- `source` in 1: raw external source pin, asynchronous.
- `button_clean` out 1: debounced button level.
- `button_press` out 1: one-cycle pulse on each `button_clean` rising edge.
- `source_clean` out 1: filtered source level.
- `source_edge` out 1: one-cycle pulse on each `source_clean` rising edge.
- `source_period` out `PERIOD_W`: cycles between the last two `source_edge` pulses.
- `period_valid` out 1: `source_period` holds a real measurement.
- `period_ovf` out 1: the last measured period saturated.

## Operation
- **Synchronizers.** Two flops per pin; both reset to 0. `b_s` and `s_s` are the second-stage outputs.
- **Debounce FSM.** States are `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`; reset state is `LOW`. Counter `dcnt` has width `$clog2(DEBOUNCE_CYCLES)+1`.
  - `LOW`: if `b_s`=1, go to `WAIT_HIGH` with `dcnt`=1.
  - `WAIT_HIGH`: if `b_s`=0, return to `LOW`. Otherwise, when `dcnt`=`DEBOUNCE_CYCLES`-1, go to `HIGH` and set `button_clean`=1 and `button_press`=1. Otherwise increment `dcnt`.
  - `HIGH` and `WAIT_LOW`: mirror image of the above. Entering `LOW` from `WAIT_LOW` sets `button_clean`=0 and produces no pulse.
- **Source filter.** A `SRC_FILTER`-deep history of `s_s` values.
  - When all samples equal 1 and `source_clean`=0, set `source_clean`=1 and pulse `source_edge`.
  - When all samples equal 0, clear `source_clean`.
- **Period measurement.**
  - Counter `pcnt` (`PERIOD_W` bits) resets to 0. On each cycle without an edge it increments, saturating at all-ones.
  - On the `source_edge` cycle:
    - if `armed`=1: `source_period` <= saturating `pcnt`+1; `period_ovf` <= 1 if that sum saturated, else 0; `period_valid` <= 1.
    - always: `pcnt` <= 0 and `armed` <= 1.
  - The first edge after reset only arms the measurement. `period_valid` stays 0 until the second edge.
- **Outputs.** All outputs are registered. Every output resets to 0.

## Timing
- A `button` change that stays stable appears on `button_clean`, with `button_press` in the same cycle, exactly `DEBOUNCE_CYCLES`+2 rising edges after the first edge that samples the new pin value.
- `source_clean` and `source_edge` follow a stable pin change by `SRC_FILTER`+2 edges.
- `source_period`, `period_valid` and `period_ovf` update in the same cycle as `source_edge`. Their values are visible on the following edge.
- Two `source_edge` pulses N cycles apart yield `source_period`=N.
- Boundary cases:
  - A bounce shorter than `DEBOUNCE_CYCLES` produces no change and no pulse. A bounce that returns during `WAIT_*` resets progress entirely.
  - `pcnt` saturates at 2^`PERIOD_W`-1 and never wraps.
  - The edge cycle's reload of `pcnt` takes priority over its increment.
  - Reset asserted mid-operation clears every register immediately, including the FSM, `armed` and `period_valid`.
  - After reset release, a pin already held high is treated as a new rising input. It yields one press or edge pulse after the normal latency.

## Structure
- `cariomart_pkg` holds:
  - the debounce state encoding (2-bit: `LOW`=0, `WAIT_HIGH`=1, `HIGH`=2, `WAIT_LOW`=3);
  - the default values of `DEBOUNCE_CYCLES`, `SRC_FILTER` and `PERIOD_W`.
- Sub-module `sync2`: parameterizable-width two-flop synchronizer with async active-low reset, instantiated once per pin.
- Debounce, filter and period logic stay in `input_conditioner`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `SRC_FILTER`=3, `PERIOD_W`=8.
1. `button` held at 1 after reset -> `button_clean` and a single `button_press` pulse at edge 10; release held low -> `button_clean`=0 at edge 10 after release, with no pulse.
2. `button` toggles 1/0 with a 5-cycle period for 60 cycles, then settles at 0 -> no `button_press` pulse and `button_clean` stays 0.
3. `source` rising edges 20 cycles apart -> first edge leaves `period_valid`=0; second edge gives `source_period`=20 and `period_valid`=1.
4. `source` edges 300 cycles apart -> `source_period`=255 and `period_ovf`=1; next edges 40 cycles apart -> `source_period`=40 and `period_ovf`=0.
5. 2-cycle `source` glitches -> no `source_edge` and `source_clean` stays 0.
6. `PRESERN` asserted mid-`WAIT_HIGH` and after `period_valid`=1 -> all outputs read 0 in the same cycle; the next edge after release only re-arms the measurement.
